ahb_decoder_mux_n: RTL

//  Parametrised AHB-Lite address decoder plus slave-to-master response mux for N slaves.

---
 rtl/ahb_decoder_mux_n.sv | 108 ++++++++++
 1 files changed

// File: rtl/ahb_decoder_mux_n.sv
// ahb_decoder_mux_n: AHB-Lite address decoder and slave response mux with built-in default slave
// Ports: HCLK/HRESETn clock and async active-low reset; HADDR/HTRANS master address phase;
//   HSEL_S one-hot slave select; HRDATA_S/HREADYOUT_S/HRESP_S packed slave responses;
//   HRDATA/HREADY/HRESP response to master (HREADY also fed back to slaves);
//   TIMEOUT_IRQ abort pulse, present only when AHB_MUX_TIMEOUT_EN is defined.
module ahb_decoder_mux_n #(
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 18,
  parameter int SEL_BITS    = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
`ifdef AHB_MUX_TIMEOUT_EN
  output logic                         TIMEOUT_IRQ,
`endif
  output logic                         HRESP
);
  localparam int NS = 1 << SEL_BITS;
  localparam logic [1:0] DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2;
  logic [SEL_BITS-1:0] idx, d_idx_q, d_idx_d;
  logic map, d_map_q, d_map_d, d_act_q, d_act_d;
  logic [1:0] ds_q, ds_d;
  logic [NS-1:0] rdy_pad, rsp_pad;
  logic [DATA_W-1:0] rd_pad [NS];
  logic s_rdy, s_rsp, ready, resp;
  logic [DATA_W-1:0] s_rd, rdata;
  logic unused_ok;
  assign idx = HADDR[SEL_LSB +: SEL_BITS];
  assign map = 32'(idx) < NUM_SLAVES;
  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NUM_SLAVES; i++) HSEL_S[i] = 32'(idx) == i;
  end
  // Slave responses padded to the full index range so unmapped indices read as zero.
  always_comb begin
    rdy_pad = '0;
    rsp_pad = '0;
    for (int i = 0; i < NS; i++) rd_pad[i] = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rdy_pad[i] = HREADYOUT_S[i];
      rsp_pad[i] = HRESP_S[i];
      rd_pad[i]  = HRDATA_S[i*DATA_W +: DATA_W];
    end
  end
  assign s_rdy = rdy_pad[d_idx_q];
  assign s_rsp = rsp_pad[d_idx_q];
  assign s_rd  = rd_pad[d_idx_q];
  assign ready = d_map_q ? s_rdy : ds_q != DS_ERR1;
  assign resp  = d_map_q ? s_rsp : ds_q != DS_IDLE;
  assign rdata = d_map_q ? s_rd : '0;
`ifdef AHB_MUX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic to_err2_q, to_err2_d, abort;
  // abort is the first ERROR cycle, to_err2_q the second; the slave is masked in both.
  assign abort = wcnt_q == WW'(TIMEOUT_CYC);
  always_comb begin
    wcnt_d    = (abort | to_err2_q | s_rdy) ? '0 : (d_act_q & d_map_q) ? wcnt_q + WW'(1) : wcnt_q;
    to_err2_d = abort;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wcnt_q    <= '0;
      to_err2_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      to_err2_q <= to_err2_d;
    end
  assign HREADY      = to_err2_q | (~abort & ready);
  assign HRESP       = abort | to_err2_q | resp;
  assign HRDATA      = (abort | to_err2_q) ? '0 : rdata;
  assign TIMEOUT_IRQ = abort;
`else
  assign HREADY = ready;
  assign HRESP  = resp;
  assign HRDATA = rdata;
`endif
  assign unused_ok = ^{HADDR, HTRANS[0], d_act_q};
  always_comb begin
    d_idx_d = HREADY ? idx : d_idx_q;
    d_map_d = HREADY ? map : d_map_q;
    d_act_d = HREADY ? HTRANS[1] : d_act_q;
    ds_d    = ds_q == DS_ERR1 ? DS_ERR2 : (HREADY & HTRANS[1] & ~map) ? DS_ERR1 : DS_IDLE;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      d_idx_q <= '0;
      d_map_q <= 1'b0;
      d_act_q <= 1'b0;
      ds_q    <= DS_IDLE;
    end else begin
      d_idx_q <= d_idx_d;
      d_map_q <= d_map_d;
      d_act_q <= d_act_d;
      ds_q    <= ds_d;
    end
endmodule
